// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage constants: datapath width and PC step derived from the memory cell layout.
package fetch_queue_pkg;
    localparam int WORD_LEN_DEF   = 16;
    localparam int CELL_BITS      = 4;
    localparam int CELLS_PER_INST = 4;
    // Memory is addressed in 4-bit cells, so one instruction advances the PC by its cell count.
    localparam int PC_STEP        = CELLS_PER_INST;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: storage, wrapping pointers and occupancy.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign rdata   = mem[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= wdata;
                tail      <= next_ptr(tail);
            end
            if (do_pop) head <= next_ptr(head);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: PC sequencing and redirect, feeding a small FIFO toward decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int WORD_LEN    = WORD_LEN_DEF,
    parameter int QUEUE_DEPTH = 2,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0,
    localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    output logic [WORD_LEN-1:0] inst_addr,
    input  logic [WORD_LEN-1:0] inst_in,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_addr,
    input  logic                id_ready,
    output logic                if_valid,
    output logic [WORD_LEN-1:0] if_instruction,
    output logic [WORD_LEN-1:0] if_pc_plus,
    output logic [CW-1:0]       q_count
);
    logic [WORD_LEN-1:0] pc_next_seq;
    logic                pop;
    logic                push;

    // Wraps modulo 2^WORD_LEN by truncation.
    assign pc_next_seq = inst_addr + WORD_LEN'(PC_STEP);
    assign if_valid    = (q_count != '0);
    assign pop         = if_valid && id_ready && !branch_taken;
    assign push        = !branch_taken && ((q_count < CW'(QUEUE_DEPTH)) || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              inst_addr <= RESET_PC;
        else if (branch_taken) inst_addr <= branch_addr;
        else if (push)         inst_addr <= pc_next_seq;
    end

    fetch_fifo #(
        .WIDTH (2 * WORD_LEN),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (branch_taken),
        .push  (push),
        .pop   (pop),
        .wdata ({inst_in, pc_next_seq}),
        .rdata ({if_instruction, if_pc_plus}),
        .count (q_count)
    );
endmodule
